// File: rtl/syncbuf_xfer_ctl.sv
// ---------------------------------------------------------------------------
// syncbuf_xfer_ctl
//
// Source-domain controller for one shared quasi-static multi-bit crossing.
// Up to NREQ requesters compete round-robin for the bus. The winner's data is
// captured into xfer_data and held stable while a single toggle request
// crosses to the destination domain through a real synchronizer. The
// destination's toggle acknowledge returns through the SYNC_STAGES-deep
// synchronizer in this block. After the ack is seen, the bus stays held for
// GUARD_CYC more cycles so the destination's unsynchronized capture gates see
// quiet data. The granted requester then gets a one-cycle req_done pulse.
//
// Ports:
//   clk           only clock of the block
//   reset         synchronous, active-high
//   req_vld       per-requester request level
//   req_data      requester i data at bits [i*DW +: DW]
//   req_done      one-cycle completion pulse to the granted requester
//   xfer_data     held crossing bus towards the syncbuf_gates inputs
//   xfer_req_tgl  request toggle towards the destination synchronizer
//   xfer_ack_tgl  ack toggle from the destination domain (asynchronous)
//   grant_id      index of the current or last granted requester
//   busy          high whenever the FSM is not idle
//   err_ack       sticky: synchronized ack changed outside WAIT_ACK
// ---------------------------------------------------------------------------
module syncbuf_xfer_ctl #(
    parameter int NREQ        = 4,
    parameter int IDW         = 2,
    parameter int DW          = 32,
    parameter int SYNC_STAGES = 2,
    parameter int GUARD_CYC   = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_vld,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      req_done,
    output logic [DW-1:0]        xfer_data,
    output logic                 xfer_req_tgl,
    input  logic                 xfer_ack_tgl,
    output logic [IDW-1:0]       grant_id,
    output logic                 busy,
    output logic                 err_ack
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT_ACK,
        GUARD
    } state_e;

    state_e               state_q, state_d;
    logic [SYNC_STAGES-1:0] ackSync_q;
    logic                 ackDly_q;
    logic                 ackS;
    logic [DW-1:0]        xferData_q, xferData_d;
    logic                 reqTgl_q, reqTgl_d;
    logic [IDW-1:0]       grantId_q, grantId_d;
    logic [IDW-1:0]       lastGrant_q, lastGrant_d;
    logic [NREQ-1:0]      reqDone_q, reqDone_d;
    logic [3:0]           guardCnt_q, guardCnt_d;
    logic                 errAck_q, errAck_d;

    logic [DW-1:0]        reqWord [NREQ];
    logic                 winValid;
    logic [IDW-1:0]       winIdx;
    logic [DW-1:0]       winData;
    int                   scanPos;

    assign ackS = ackSync_q[SYNC_STAGES-1];

    // Split the flat request data bus into one word per requester so the
    // arbiter can pick a word with a small index instead of a wide shift.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            reqWord[i] = req_data[i*DW +: DW];
        end
    end

    // Round-robin pick: scan from the requester after the last winner,
    // wrapping modulo NREQ, and take the first one asserting req_vld.
    // The last winner is scanned last, which gives it the lowest priority.
    always_comb begin
        winValid = 1'b0;
        winIdx   = '0;
        winData  = '0;
        scanPos  = 0;
        for (int k = 1; k <= NREQ; k++) begin
            scanPos = int'(lastGrant_q) + k;
            if (scanPos >= NREQ) begin
                scanPos = scanPos - NREQ;
            end
            if (!winValid && req_vld[scanPos[IW-1:0]]) begin
                winValid = 1'b1;
                winIdx   = IDW'(scanPos);
                winData  = reqWord[scanPos[IW-1:0]];
            end
        end
    end

    // Ack synchronizer chain plus one extra flop for change detection.
    // The extra flop lets err_ack see any edge of the synchronized ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            ackSync_q <= '0;
            ackDly_q  <= 1'b0;
        end else begin
            ackSync_q <= {ackSync_q[SYNC_STAGES-2:0], xfer_ack_tgl};
            ackDly_q  <= ackS;
        end
    end

    // Next-state logic. The bus only ever loads on leaving IDLE, so the
    // destination sees quasi-static data for the whole handshake and guard.
    // The ack is complete when the synchronized ack toggle has caught up
    // with our request toggle.
    always_comb begin
        state_d     = state_q;
        xferData_d  = xferData_q;
        reqTgl_d    = reqTgl_q;
        grantId_d   = grantId_q;
        lastGrant_d = lastGrant_q;
        reqDone_d   = '0;
        guardCnt_d  = guardCnt_q;
        errAck_d    = errAck_q;

        // An ack edge is only legal while waiting for it; the cycle that
        // leaves WAIT_ACK is still evaluated against the old state.
        if ((state_q != WAIT_ACK) && (ackS != ackDly_q)) begin
            errAck_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (winValid) begin
                    xferData_d  = winData;
                    grantId_d   = winIdx;
                    lastGrant_d = winIdx;
                    state_d     = LOAD;
                end
            end
            LOAD: begin
                reqTgl_d = ~reqTgl_q;
                state_d  = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (ackS == reqTgl_q) begin
                    reqDone_d = NREQ'(1) << grantId_q;
                    if (GUARD_CYC == 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d    = GUARD;
                        guardCnt_d = 4'(GUARD_CYC);
                    end
                end
            end
            GUARD: begin
                guardCnt_d = guardCnt_q - 4'd1;
                if (guardCnt_q <= 4'd1) begin
                    guardCnt_d = '0;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers. last_grant starts at NREQ-1 so that
    // requester 0 is first in line after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            xferData_q  <= '0;
            reqTgl_q    <= 1'b0;
            grantId_q   <= '0;
            lastGrant_q <= IDW'(NREQ - 1);
            reqDone_q   <= '0;
            guardCnt_q  <= '0;
            errAck_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            xferData_q  <= xferData_d;
            reqTgl_q    <= reqTgl_d;
            grantId_q   <= grantId_d;
            lastGrant_q <= lastGrant_d;
            reqDone_q   <= reqDone_d;
            guardCnt_q  <= guardCnt_d;
            errAck_q    <= errAck_d;
        end
    end

    assign req_done     = reqDone_q;
    assign xfer_data    = xferData_q;
    assign xfer_req_tgl = reqTgl_q;
    assign grant_id     = grantId_q;
    assign busy         = (state_q != IDLE);
    assign err_ack      = errAck_q;

endmodule

// File: doc/syncbuf_xfer_ctl.md
# syncbuf_xfer_ctl

Source-domain controller that shares one quasi-static multi-bit crossing between NREQ requesters. The data bus it drives passes unsynchronized through `syncbuf_gates` instances into the destination domain. Only a single toggle-request bit crosses through a real synchronizer, and the destination's toggle-acknowledge returns through a synchronizer inside this block. The block arbitrates round-robin, holds the bus stable for the whole transfer plus a guard interval, and reports completion to each requester.

## Interface
- NREQ, 4: number of requesters (2..8)
- IDW, 2: width of grant_id; must satisfy 2**IDW >= NREQ
- DW, 32: crossing data width
- SYNC_STAGES, 2: flops in the internal ack synchronizer (2..4)
- GUARD_CYC, 2: cycles the bus stays held after ack detection (0..15)

- clk  in  1  only clock of the block
- reset  in  1  synchronous, active-high
- req_vld  in  NREQ  per-requester transfer request, level
- req_data  in  NREQ*DW  requester i data at bits [i*DW +: DW]
- req_done  out  NREQ  one-cycle completion pulse to the granted requester
- xfer_data  out  DW  held crossing bus, to the syncbuf_gates inputs
- xfer_req_tgl  out  1  request toggle, to the destination synchronizer
- xfer_ack_tgl  in  1  ack toggle from the destination domain (asynchronous)
- grant_id  out  IDW  index of the current or last granted requester
- busy  out  1  high whenever state != IDLE
- err_ack  out  1  sticky protocol error: the synchronized ack changed outside WAIT_ACK

## Operation
- Ack path: `xfer_ack_tgl` feeds a chain of SYNC_STAGES flops. `ack_s` is the last stage; `ack_d` is `ack_s` delayed by one flop, used for change detection.
- FSM states: IDLE, LOAD, WAIT_ACK, GUARD.
  - **IDLE:** if any `req_vld` is set, pick the first set bit scanning from `last_grant+1` modulo NREQ. Register `req_data` of the winner into `xfer_data`, set `grant_id` and `last_grant`, and go to LOAD. Otherwise stay.
  - **LOAD:** one setup cycle with the bus already stable. Invert `xfer_req_tgl`, then go to WAIT_ACK.
  - **WAIT_ACK:** when `ack_s == xfer_req_tgl`, pulse `req_done[grant_id]` for one cycle. Go to GUARD, loading the guard counter with GUARD_CYC. If GUARD_CYC is 0, go directly to IDLE.
  - **GUARD:** decrement the counter each cycle and go to IDLE when it reaches 1.
- `xfer_data` changes only on the IDLE→LOAD edge. It holds its value in every other state, including IDLE after completion.
- Requester contract: hold `req_vld` and data until `req_done`.
  - If `req_vld` drops after the grant, the transfer still completes and `req_done` still pulses.
  - A requester that keeps `req_vld` high after `req_done` is treated as a new request.
- Round-robin: the winner of a grant has the lowest priority at the next arbitration, so no requester waits more than NREQ-1 transfers.
- err_ack: set when `ack_s != ack_d` while the state is not WAIT_ACK. A legal ack toggle entering GUARD in the same cycle does not set it. Only reset clears it; the FSM ignores it.
- Simultaneous events: arbitration happens only in IDLE. Requests arriving in other states wait. A request that rises and falls entirely while busy is not served.

## Timing
- Reset values:
  - FSM state IDLE.
  - `xfer_data` 0, `xfer_req_tgl` 0, `req_done` 0, `busy` 0, `err_ack` 0, `grant_id` 0.
  - `last_grant` NREQ-1, so requester 0 wins first. Guard counter 0, all sync flops 0.
- Reset mid-transfer abandons the transfer; no `req_done` is issued. The destination domain must be reset together so that `xfer_ack_tgl` is 0 after reset.
- Edge E0 samples `req_vld` in IDLE:
  - `xfer_data`, `grant_id` and `busy` are valid after E0.
  - `xfer_req_tgl` toggles after E1.
- With ack looped back (`xfer_ack_tgl` = `xfer_req_tgl`):
  - `req_done` is high during the cycle after edge E(SYNC_STAGES+2). With defaults that is after E4.
  - The next IDLE arbitration edge is E(SYNC_STAGES+GUARD_CYC+3), i.e. E7 with defaults, which is also the back-to-back transfer period.
- An external ack delay of D cycles adds D to all of the above.

## Test plan
- **Single loopback transfer** (defaults): req_vld=0001, data0=0xA5A5_0001 → xfer_data=0xA5A5_0001 after E0, xfer_req_tgl 0→1 after E1, req_done=0001 for one cycle after E4, busy falls after E6.
- **All four requesting continuously, loopback:** grant order 0,1,2,3,0,1. Each req_done is spaced 7 cycles apart. xfer_data matches each requester's data.
- **Fairness:** req 2 held high, req 0 raised during req 2's transfer. The next grant goes to 0 (scan starts at 3, wraps to 0), then back to 2.
- **Delayed ack:** the destination model returns the ack toggle 20 cycles late. xfer_data stays constant the whole time, req_done occurs 20 cycles later than in loopback, and err_ack stays 0.
- **Spurious ack:** toggle xfer_ack_tgl while in IDLE → err_ack=1 SYNC_STAGES+1 cycles later and stays 1. The next transfer still runs normally.
- **Reset in WAIT_ACK:** assert reset for one cycle → all outputs return to their reset values, no req_done pulses, and the next grant goes to requester 0.
